// File: rtl/raster_tri_scheduler.sv
// raster_tri_scheduler: buffers triangle setup records in a small FIFO and
// issues them one at a time to the rasterizer backend (dv/ready/done), tracking
// frame boundaries through the per-record last flag.
// Optional feature macro: RASTER_SCHED_CULL_EN -- drop records whose bounding
// box is inverted (br < tl on either axis) without involving the backend.
module raster_tri_scheduler #(
   parameter int DATAWIDTH  = 12,
   parameter int REC_WIDTH  = 228,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [REC_WIDTH-1:0] s_data,
   input  logic                 s_last,
   input  logic                 frame_start,
   output logic [REC_WIDTH-1:0] rb_data,
   output logic                 rb_dv,
   output logic                 rb_last,
   input  logic                 rb_ready,
   input  logic                 rb_done,
   output logic                 frame_busy,
   output logic                 frame_done,
   output logic [CNT_WIDTH-1:0] tri_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef RASTER_SCHED_CULL_EN
   localparam bit CULL_EN = 1'b1;
`else
   localparam bit CULL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, WAIT_DONE, FINISH} state_t;

   state_t state, next_state;

   // Record storage; data and last flag live side by side per entry.
   logic [REC_WIDTH-1:0]  mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_last;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        count;

   logic                  push, pop, dispatch;
   logic                  full, empty;
   logic [REC_WIDTH-1:0]  head_data;
   logic                  head_last;

   // Bounding-box fields of the head record, used for the inverted-box test.
   logic signed [DATAWIDTH-1:0] tl_x, tl_y, br_x, br_y;
   logic                        head_inverted, head_cull;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign s_ready = !full;
   // A full FIFO refuses the push even when the FSM pops in the same cycle.
   assign push    = s_valid && !full;

   assign head_data = mem_data[rd_ptr];
   assign head_last = mem_last[rd_ptr];

   assign tl_x = head_data[DATAWIDTH-1:0];
   assign tl_y = head_data[2*DATAWIDTH-1:DATAWIDTH];
   assign br_x = head_data[3*DATAWIDTH-1:2*DATAWIDTH];
   assign br_y = head_data[4*DATAWIDTH-1:3*DATAWIDTH];

   assign head_inverted = (br_x < tl_x) || (br_y < tl_y);
   assign head_cull     = CULL_EN && head_inverted;

   // Entry write; storage itself needs no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= s_data;
         mem_last[wr_ptr] <= s_last;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and pop/dispatch decisions; stray frame_start/rb_done are ignored
   // simply because only IDLE/WAIT_DONE look at them.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      dispatch   = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) next_state = RUN;
         end
         RUN: begin
            if (!empty) begin
               if (head_cull) begin
                  // Culled records drain one per cycle, independent of rb_ready.
                  pop = 1'b1;
                  if (head_last) next_state = FINISH;
               end else if (rb_ready) begin
                  pop        = 1'b1;
                  dispatch   = 1'b1;
                  next_state = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (rb_done) next_state = rb_last ? FINISH : RUN;
         end
         FINISH: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Registered outputs. frame_done/frame_busy are decoded from next_state so
   // they line up with the cycle the FSM actually occupies the state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rb_dv      <= 1'b0;
         rb_data    <= '0;
         rb_last    <= 1'b0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
         tri_count  <= '0;
      end else begin
         rb_dv      <= dispatch;
         frame_done <= (next_state == FINISH);
         frame_busy <= (next_state == RUN) || (next_state == WAIT_DONE);
         if (dispatch) begin
            rb_data <= head_data;
            rb_last <= head_last;
         end
         if (state == IDLE && frame_start)
            tri_count <= '0;
         else if (dispatch && tri_count != '1)
            tri_count <= tri_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_raster_tri_scheduler.sv
// Directed bench for raster_tri_scheduler: single-triangle frame, FIFO full,
// backend stall, spurious inputs, reset mid-frame, and inverted-box records.
module tb_raster_tri_scheduler;

   localparam int DATAWIDTH  = 12;
   localparam int REC_WIDTH  = 228;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_WIDTH  = 16;

   logic                 clk;
   logic                 rstn;
   logic                 s_valid;
   logic                 s_ready;
   logic [REC_WIDTH-1:0] s_data;
   logic                 s_last;
   logic                 frame_start;
   logic [REC_WIDTH-1:0] rb_data;
   logic                 rb_dv;
   logic                 rb_last;
   logic                 rb_ready;
   logic                 rb_done;
   logic                 frame_busy;
   logic                 frame_done;
   logic [CNT_WIDTH-1:0] tri_count;

   int vectors;
   int miscompares;

   raster_tri_scheduler #(
      .DATAWIDTH (DATAWIDTH),
      .REC_WIDTH (REC_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .frame_start(frame_start),
      .rb_data    (rb_data),
      .rb_dv      (rb_dv),
      .rb_last    (rb_last),
      .rb_ready   (rb_ready),
      .rb_done    (rb_done),
      .frame_busy (frame_busy),
      .frame_done (frame_done),
      .tri_count  (tri_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record with id-derived bbox; inv makes br x = tl x - 1.
   function automatic logic [REC_WIDTH-1:0] rec(input int id, input bit inv);
      logic [REC_WIDTH-1:0] r;
      logic [31:0] v;
      v = id;
      r = '0;
      r[11:0]  = 12'(id);
      r[23:12] = 12'(id + 1);
      r[35:24] = inv ? 12'(id - 1) : 12'(id + 5);
      r[47:36] = 12'(id + 6);
      for (int b = 48; b < REC_WIDTH; b++) r[b] = v[b % 8] ^ b[0];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [REC_WIDTH-1:0] obs,
                      input logic [REC_WIDTH-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [REC_WIDTH-1:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic fstart();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic done_pulse();
      rb_done = 1'b1;
      tick();
      rb_done = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_ready"},    REC_WIDTH'(s_ready),    REC_WIDTH'(1));
      chk({tag, "_rb_dv"},      REC_WIDTH'(rb_dv),      REC_WIDTH'(0));
      chk({tag, "_rb_last"},    REC_WIDTH'(rb_last),    REC_WIDTH'(0));
      chk({tag, "_rb_data"},    rb_data,                REC_WIDTH'(0));
      chk({tag, "_frame_busy"}, REC_WIDTH'(frame_busy), REC_WIDTH'(0));
      chk({tag, "_frame_done"}, REC_WIDTH'(frame_done), REC_WIDTH'(0));
      chk({tag, "_tri_count"},  REC_WIDTH'(tri_count),  REC_WIDTH'(0));
   endtask

   initial begin
      int bad;
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      s_valid     = 1'b0;
      s_data      = '0;
      s_last      = 1'b0;
      frame_start = 1'b0;
      rb_ready    = 1'b1;
      rb_done     = 1'b0;
      tick();
      tick();
      chk_reset_vals("rst");
      rstn = 1'b1;
      tick();

      // Single triangle frame.
      push(rec(1, 0), 1'b1);
      fstart();
      chk("t1_busy", REC_WIDTH'(frame_busy), REC_WIDTH'(1));
      chk("t1_nodv", REC_WIDTH'(rb_dv),      REC_WIDTH'(0));
      tick();
      chk("t1_dv",   REC_WIDTH'(rb_dv),      REC_WIDTH'(1));
      chk("t1_data", rb_data,                rec(1, 0));
      chk("t1_last", REC_WIDTH'(rb_last),    REC_WIDTH'(1));
      chk("t1_cnt",  REC_WIDTH'(tri_count),  REC_WIDTH'(1));
      tick();
      chk("t1_dv_pulse", REC_WIDTH'(rb_dv),  REC_WIDTH'(0));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("t1_spur_cnt",  REC_WIDTH'(tri_count),  REC_WIDTH'(1));
      chk("t1_spur_busy", REC_WIDTH'(frame_busy), REC_WIDTH'(1));
      repeat (17) tick();
      chk("t1_hold", rb_data, rec(1, 0));
      done_pulse();
      chk("t1_done",     REC_WIDTH'(frame_done), REC_WIDTH'(1));
      chk("t1_busy_off", REC_WIDTH'(frame_busy), REC_WIDTH'(0));
      chk("t1_cnt_end",  REC_WIDTH'(tri_count),  REC_WIDTH'(1));
      tick();
      chk("t1_done_pulse", REC_WIDTH'(frame_done), REC_WIDTH'(0));
      chk("t1_cnt_hold",   REC_WIDTH'(tri_count),  REC_WIDTH'(1));

      // FIFO full: 5 records, 5th accepted only after first dispatch.
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = rec(10 + i, 0);
         s_last  = 1'b0;
         chk("t2_ready", REC_WIDTH'(s_ready), REC_WIDTH'(1));
         tick();
      end
      s_data = rec(14, 0);
      s_last = 1'b1;
      chk("t2_full", REC_WIDTH'(s_ready), REC_WIDTH'(0));
      fstart();
      chk("t2_full_hold", REC_WIDTH'(s_ready),   REC_WIDTH'(0));
      chk("t2_cnt_clr",   REC_WIDTH'(tri_count), REC_WIDTH'(0));
      tick();
      chk("t2_dv0",   REC_WIDTH'(rb_dv), REC_WIDTH'(1));
      chk("t2_data0", rb_data,           rec(10, 0));
      chk("t2_room",  REC_WIDTH'(s_ready), REC_WIDTH'(1));
      tick();
      s_valid = 1'b0;
      chk("t2_refull", REC_WIDTH'(s_ready), REC_WIDTH'(0));
      for (int k = 11; k <= 14; k++) begin
         done_pulse();
         chk("t2_gap",  REC_WIDTH'(rb_dv),   REC_WIDTH'(0));
         tick();
         chk("t2_dv",   REC_WIDTH'(rb_dv),   REC_WIDTH'(1));
         chk("t2_data", rb_data,             rec(k, 0));
         chk("t2_last", REC_WIDTH'(rb_last), REC_WIDTH'(k == 14));
      end
      done_pulse();
      chk("t2_done", REC_WIDTH'(frame_done), REC_WIDTH'(1));
      chk("t2_cnt",  REC_WIDTH'(tri_count),  REC_WIDTH'(5));
      tick();

      // Backend stall with a full FIFO; 22/23 stay queued past the last record.
      push(rec(20, 0), 1'b0);
      push(rec(21, 0), 1'b1);
      push(rec(22, 0), 1'b0);
      push(rec(23, 0), 1'b0);
      rb_ready = 1'b0;
      fstart();
      chk("t3_cnt_clr", REC_WIDTH'(tri_count), REC_WIDTH'(0));
      bad = 0;
      repeat (15) begin
         tick();
         if (rb_dv !== 1'b0 || s_ready !== 1'b0) bad++;
      end
      chk("t3_stall", REC_WIDTH'(bad), REC_WIDTH'(0));
      rb_ready = 1'b1;
      tick();
      chk("t3_dv",   REC_WIDTH'(rb_dv),     REC_WIDTH'(1));
      chk("t3_data", rb_data,               rec(20, 0));
      chk("t3_cnt",  REC_WIDTH'(tri_count), REC_WIDTH'(1));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("t3_spurfs_cnt",  REC_WIDTH'(tri_count),  REC_WIDTH'(1));
      chk("t3_spurfs_busy", REC_WIDTH'(frame_busy), REC_WIDTH'(1));
      done_pulse();
      rb_ready    = 1'b0;
      frame_start = 1'b1;
      rb_done     = 1'b1;
      tick();
      frame_start = 1'b0;
      rb_done     = 1'b0;
      chk("t3_spur_dv",   REC_WIDTH'(rb_dv),      REC_WIDTH'(0));
      chk("t3_spur_cnt",  REC_WIDTH'(tri_count),  REC_WIDTH'(1));
      chk("t3_spur_busy", REC_WIDTH'(frame_busy), REC_WIDTH'(1));
      chk("t3_spur_done", REC_WIDTH'(frame_done), REC_WIDTH'(0));
      rb_ready = 1'b1;
      tick();
      chk("t3_dv2",   REC_WIDTH'(rb_dv),     REC_WIDTH'(1));
      chk("t3_data2", rb_data,               rec(21, 0));
      chk("t3_last2", REC_WIDTH'(rb_last),   REC_WIDTH'(1));
      chk("t3_cnt2",  REC_WIDTH'(tri_count), REC_WIDTH'(2));
      done_pulse();
      chk("t3_done", REC_WIDTH'(frame_done), REC_WIDTH'(1));
      tick();
      chk("t3_queued", REC_WIDTH'(s_ready), REC_WIDTH'(1));

      // Reset during WAIT_DONE with records still queued.
      push(rec(24, 0), 1'b0);
      push(rec(25, 0), 1'b0);
      fstart();
      tick();
      chk("t4_dv",   REC_WIDTH'(rb_dv), REC_WIDTH'(1));
      chk("t4_data", rb_data,           rec(22, 0));
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk_reset_vals("t4_rst");
      tick();
      fstart();
      bad = 0;
      repeat (3) begin
         tick();
         if (rb_dv !== 1'b0) bad++;
      end
      chk("t4_empty", REC_WIDTH'(bad), REC_WIDTH'(0));
      push(rec(30, 0), 1'b1);
      chk("t4_nodv", REC_WIDTH'(rb_dv), REC_WIDTH'(0));
      tick();
      chk("t4_dv2",   REC_WIDTH'(rb_dv),     REC_WIDTH'(1));
      chk("t4_data2", rb_data,               rec(30, 0));
      chk("t4_cnt",   REC_WIDTH'(tri_count), REC_WIDTH'(1));
      done_pulse();
      chk("t4_done", REC_WIDTH'(frame_done), REC_WIDTH'(1));
      tick();

      // Inverted-box record in the middle of a 3-record frame.
      push(rec(40, 0), 1'b0);
      push(rec(41, 1), 1'b0);
      push(rec(42, 0), 1'b1);
      fstart();
      tick();
      chk("t5_dv0",   REC_WIDTH'(rb_dv), REC_WIDTH'(1));
      chk("t5_data0", rb_data,           rec(40, 0));
      done_pulse();
      tick();
`ifdef RASTER_SCHED_CULL_EN
      chk("t5_cull_nodv", REC_WIDTH'(rb_dv), REC_WIDTH'(0));
      chk("t5_cull_hold", rb_data,           rec(40, 0));
      tick();
      chk("t5_dv2",   REC_WIDTH'(rb_dv),     REC_WIDTH'(1));
      chk("t5_data2", rb_data,               rec(42, 0));
      chk("t5_cnt2",  REC_WIDTH'(tri_count), REC_WIDTH'(2));
      done_pulse();
      chk("t5_done", REC_WIDTH'(frame_done), REC_WIDTH'(1));
      chk("t5_cnt",  REC_WIDTH'(tri_count),  REC_WIDTH'(2));
`else
      chk("t5_dv1",   REC_WIDTH'(rb_dv),     REC_WIDTH'(1));
      chk("t5_data1", rb_data,               rec(41, 1));
      chk("t5_cnt1",  REC_WIDTH'(tri_count), REC_WIDTH'(2));
      done_pulse();
      chk("t5_nodone", REC_WIDTH'(frame_done), REC_WIDTH'(0));
      tick();
      chk("t5_dv2",   REC_WIDTH'(rb_dv),     REC_WIDTH'(1));
      chk("t5_data2", rb_data,               rec(42, 0));
      done_pulse();
      chk("t5_done", REC_WIDTH'(frame_done), REC_WIDTH'(1));
      chk("t5_cnt",  REC_WIDTH'(tri_count),  REC_WIDTH'(3));
`endif
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
